axi_mem_slave: RTL and testbench
================================

AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameter MEM_WORDS, default 256, sets the number of 64-bit memory words (power of 2).
REQ-002 Port clk, in, 1: the only clock; all state updates on its rising edge.
REQ-003 Port rst, in, 1: reset, synchronous and active-high.
REQ-004 Port r_slave0_ar_msg, in, 44: {id[43:40], addr[39:8], len[7:0]}; beats = len+1.
REQ-005 Port r_slave0_ar_val / r_slave0_ar_rdy, in / out, 1 / 1: AR handshake.
REQ-006 Port r_slave0_r_msg, out, 71: {id[70:67], data[66:3], resp[2:1], last[0]}.
REQ-007 Port r_slave0_r_val / r_slave0_r_rdy, out / in, 1 / 1: R handshake.
REQ-008 Port w_slave0_aw_msg, in, 44: same packing as AR.
REQ-009 Port w_slave0_aw_val / w_slave0_aw_rdy, in / out, 1 / 1: AW handshake.
REQ-010 Port w_slave0_w_msg, in, 73: {data[72:9], strb[8:1], last[0]}.
REQ-011 Port w_slave0_w_val / w_slave0_w_rdy, in / out, 1 / 1: W handshake.
REQ-012 Port w_slave0_b_msg, out, 6: {id[5:2], resp[1:0]}.
REQ-013 Port w_slave0_b_val / w_slave0_b_rdy, out / in, 1 / 1: B handshake.

Function
REQ-014 A transfer occurs only in a cycle where val and rdy are both high; once raised, a val SHALL hold high with a stable msg until that transfer.
REQ-015 Read FSM: RD_IDLE (ar_rdy=1) -> RD_BURST on AR transfer; RD_BURST -> RD_IDLE on the R transfer with last=1.
REQ-016 The first R beat SHALL be valid the cycle after the AR transfer; subsequent beats SHALL be issued back-to-back while r_rdy=1.
REQ-017 Beat address = aligned base (addr[2:0] forced to 0) + 8*beat, computed modulo 2^32; addr bits [log2(MEM_WORDS)+2:3] select the word.
REQ-018 A beat whose byte address is >= 8*MEM_WORDS SHALL return data 0 and resp 2'b11 (DECERR); otherwise it returns resp 2'b00.
REQ-019 The R id SHALL equal the AR id; last SHALL be 1 only on beat len.
REQ-020 Write FSM: WR_IDLE (aw_rdy=1) -> WR_DATA on AW transfer (w_rdy=1) -> WR_RESP after beat len is transferred (b_val=1) -> WR_IDLE on B transfer.
REQ-021 Each W beat SHALL write the bytes whose strb bit is 1 at the beat address; out-of-range beats SHALL be discarded and latch resp DECERR.
REQ-022 A W last flag that differs from (beat==len) SHALL latch resp SLVERR (2'b10); the burst length is still governed by len; DECERR takes priority over SLVERR.
REQ-023 The B id SHALL equal the AW id; resp is the latched value, cleared on entry to WR_DATA.
REQ-024 Read and write bursts SHALL proceed concurrently; a same-cycle read and write to one word SHALL return the old data.
REQ-025 w_rdy SHALL be 0 outside WR_DATA; W beats presented before the AW transfer are not accepted.

Reset
REQ-026 While rst=1: both FSMs go to IDLE; ar_rdy=0, aw_rdy=0, w_rdy=0, r_val=0, b_val=0, r_msg=0, b_msg=0.
REQ-027 Reset asserted mid-burst SHALL abandon the burst without further R or B beats; memory contents are not cleared.
REQ-028 ar_rdy and aw_rdy SHALL rise in the first cycle after rst falls.

Structure
REQ-029 Package axi_mem_pkg SHALL hold the field widths (ID=4, ADDR=32, LEN=8, DATA=64, STRB=8), the response codes OKAY/SLVERR/DECERR, and the message field offsets.
REQ-030 Sub-module axi_mem_ram SHALL implement MEM_WORDS x 64 storage with 1 registered-read port and 1 byte-enabled write port.

Verification
REQ-031 AW id=3, addr=0x10, len=1; W 0xA5A5..A5, strb=0xFF, then 0x1234, strb=0x03, last=1 -> B {id=3, resp=OKAY}; memory word 2 = 0xA5..A5; word 3 low 16 bits = 0x1234.
REQ-032 AR id=5, addr=0x10, len=1, r_rdy held 1 -> two R beats on consecutive cycles, first one cycle after AR; data as written; last only on beat 2; id=5.
REQ-033 AR addr=0x7F8, len=1 with MEM_WORDS=256 -> beat 0 OKAY with word 255; beat 1 DECERR with data 0.
REQ-034 AW len=2 with last=1 on beat 1 -> all 3 beats accepted; B resp=SLVERR.
REQ-035 r_rdy toggled randomly during an 8-beat read -> r_msg stable while stalled; 8 beats in order; no drop or duplicate.
REQ-036 rst pulsed during beat 2 of a 4-beat read -> no further R beats; the next AR is served normally with an OKAY response.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// axi_mem_pkg: field widths, response codes, message offsets and FSM states for axi_mem_slave
package axi_mem_pkg;
    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int LEN_W  = 8;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;
    localparam int WORD_W = ADDR_W - 3;
    localparam int AX_LEN_LSB  = 0;
    localparam int AX_ADDR_LSB = 8;
    localparam int AX_ID_LSB   = 40;
    localparam int R_LAST      = 0;
    localparam int R_RESP_LSB  = 1;
    localparam int R_DATA_LSB  = 3;
    localparam int R_ID_LSB    = 67;
    localparam int W_LAST      = 0;
    localparam int W_STRB_LSB  = 1;
    localparam int W_DATA_LSB  = 9;
    localparam int B_RESP_LSB  = 0;
    localparam int B_ID_LSB    = 2;
    typedef logic [1:0] resp_t;
    localparam resp_t RESP_OKAY   = 2'b00;
    localparam resp_t RESP_SLVERR = 2'b10;
    localparam resp_t RESP_DECERR = 2'b11;
    typedef enum logic {RD_IDLE, RD_BURST} rd_state_t;
    typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
    // Word address of a beat; wrapping at 2^29 words equals byte wrap at 2^32.
    function automatic logic [WORD_W-1:0] beat_word(input logic [WORD_W-1:0] base, input logic [LEN_W-1:0] beat);
        return base + WORD_W'(beat);
    endfunction
endpackage

// File: rtl/axi_mem_ram.sv
// axi_mem_ram: WORDS x 64-bit storage, one registered read port and one byte-enabled write port
module axi_mem_ram
    import axi_mem_pkg::*;
#(
    parameter int WORDS = 256,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_addr,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [STRB_W-1:0] wr_strb,
    input  logic [DATA_W-1:0] wr_data
);
    logic [DATA_W-1:0] mem [WORDS];
    // byte-masked write; read register holds its value when rd_en is low and sees pre-write data
    always_ff @(posedge clk) begin
        if (wr_en)
            for (int i = 0; i < STRB_W; i++)
                if (wr_strb[i]) mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
        if (rd_en) rd_data <= mem[rd_addr];
    end
endmodule

// File: rtl/axi_mem_slave.sv
// axi_mem_slave: AXI-style burst memory slave with independent read and write channels
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [43:0] r_slave0_ar_msg,
    input  logic        r_slave0_ar_val,
    output logic        r_slave0_ar_rdy,
    output logic [70:0] r_slave0_r_msg,
    output logic        r_slave0_r_val,
    input  logic        r_slave0_r_rdy,
    input  logic [43:0] w_slave0_aw_msg,
    input  logic        w_slave0_aw_val,
    output logic        w_slave0_aw_rdy,
    input  logic [72:0] w_slave0_w_msg,
    input  logic        w_slave0_w_val,
    output logic        w_slave0_w_rdy,
    output logic [5:0]  w_slave0_b_msg,
    output logic        w_slave0_b_val,
    input  logic        w_slave0_b_rdy
);
    localparam int AW = $clog2(MEM_WORDS);
    rd_state_t rd_state, rd_next;
    wr_state_t wr_state, wr_next;
    logic [ID_W-1:0] rd_id, wr_id;
    logic [WORD_W-1:0] rd_base, wr_base, wr_word;
    logic [LEN_W-1:0] rd_len, rd_beat, wr_len, wr_beat;
    resp_t wr_resp, wr_resp_next;
    logic ar_fire, r_fire, aw_fire, w_fire, b_fire;
    logic rd_last, rd_ok, wr_last, wr_ok, ram_ren;
    logic [AW-1:0] ram_raddr;
    logic [DATA_W-1:0] ram_rdata;
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{r_slave0_ar_msg[AX_ADDR_LSB +: 3], w_slave0_aw_msg[AX_ADDR_LSB +: 3]};
    assign r_slave0_ar_rdy = !rst && rd_state == RD_IDLE;
    assign r_slave0_r_val  = !rst && rd_state == RD_BURST;
    assign w_slave0_aw_rdy = !rst && wr_state == WR_IDLE;
    assign w_slave0_w_rdy  = !rst && wr_state == WR_DATA;
    assign w_slave0_b_val  = !rst && wr_state == WR_RESP;
    assign ar_fire = r_slave0_ar_val && r_slave0_ar_rdy;
    assign r_fire  = r_slave0_r_val && r_slave0_r_rdy;
    assign aw_fire = w_slave0_aw_val && w_slave0_aw_rdy;
    assign w_fire  = w_slave0_w_val && w_slave0_w_rdy;
    assign b_fire  = w_slave0_b_val && w_slave0_b_rdy;
    assign rd_last = rd_beat == rd_len;
    assign rd_ok   = beat_word(rd_base, rd_beat) < WORD_W'(MEM_WORDS);
    assign ram_ren = ar_fire || (r_fire && !rd_last);
    // The RAM read is launched one cycle ahead: beat 0 on the AR transfer, beat n+1 on transfer of beat n.
    assign ram_raddr = ar_fire ? r_slave0_ar_msg[AX_ADDR_LSB+3 +: AW] : rd_base[AW-1:0] + AW'(rd_beat + 8'd1);
    assign wr_word = beat_word(wr_base, wr_beat);
    assign wr_ok   = wr_word < WORD_W'(MEM_WORDS);
    assign wr_last = wr_beat == wr_len;
    assign wr_resp_next = (!wr_ok || wr_resp == RESP_DECERR) ? RESP_DECERR :
                          (w_slave0_w_msg[W_LAST] != wr_last || wr_resp == RESP_SLVERR) ? RESP_SLVERR : RESP_OKAY;
    axi_mem_ram #(.WORDS(MEM_WORDS)) u_ram (
        .clk     (clk),
        .rd_en   (ram_ren),
        .rd_addr (ram_raddr),
        .rd_data (ram_rdata),
        .wr_en   (w_fire && wr_ok),
        .wr_addr (wr_word[AW-1:0]),
        .wr_strb (w_slave0_w_msg[W_STRB_LSB +: STRB_W]),
        .wr_data (w_slave0_w_msg[W_DATA_LSB +: DATA_W])
    );
    // read next state and R message; out-of-range beats return zero data with DECERR
    always_comb begin
        rd_next = rd_state;
        r_slave0_r_msg = '0;
        if (rd_state == RD_IDLE && ar_fire) rd_next = RD_BURST;
        if (rd_state == RD_BURST && r_fire && rd_last) rd_next = RD_IDLE;
        if (r_slave0_r_val) begin
            r_slave0_r_msg[R_ID_LSB +: ID_W] = rd_id;
            r_slave0_r_msg[R_DATA_LSB +: DATA_W] = ram_rdata & {DATA_W{rd_ok}};
            r_slave0_r_msg[R_RESP_LSB +: 2] = rd_ok ? RESP_OKAY : RESP_DECERR;
            r_slave0_r_msg[R_LAST] = rd_last;
        end
    end
    // write next state and B message
    always_comb begin
        wr_next = wr_state;
        w_slave0_b_msg = '0;
        case (wr_state)
            WR_IDLE: if (aw_fire) wr_next = WR_DATA;
            WR_DATA: if (w_fire && wr_last) wr_next = WR_RESP;
            WR_RESP: if (b_fire) wr_next = WR_IDLE;
            default: wr_next = WR_IDLE;
        endcase
        if (w_slave0_b_val) begin
            w_slave0_b_msg[B_ID_LSB +: ID_W] = wr_id;
            w_slave0_b_msg[B_RESP_LSB +: 2] = wr_resp;
        end
    end
    // state registers
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_state <= RD_IDLE;
            wr_state <= WR_IDLE;
        end else begin
            rd_state <= rd_next;
            wr_state <= wr_next;
        end
    end
    // burst context: captured on address transfer, beat counters advance per data transfer
    always_ff @(posedge clk) begin
        if (ar_fire) begin
            rd_id   <= r_slave0_ar_msg[AX_ID_LSB +: ID_W];
            rd_base <= r_slave0_ar_msg[AX_ADDR_LSB+3 +: WORD_W];
            rd_len  <= r_slave0_ar_msg[AX_LEN_LSB +: LEN_W];
            rd_beat <= '0;
        end else if (r_fire) begin
            rd_beat <= rd_beat + 1'b1;
        end
        if (aw_fire) begin
            wr_id   <= w_slave0_aw_msg[AX_ID_LSB +: ID_W];
            wr_base <= w_slave0_aw_msg[AX_ADDR_LSB+3 +: WORD_W];
            wr_len  <= w_slave0_aw_msg[AX_LEN_LSB +: LEN_W];
            wr_beat <= '0;
            wr_resp <= RESP_OKAY;
        end else if (w_fire) begin
            wr_beat <= wr_beat + 1'b1;
            wr_resp <= wr_resp_next;
        end
    end
endmodule

// File: tb/tb_axi_mem_slave.sv
// tb_axi_mem_slave: directed table-driven and sequence checks for axi_mem_slave
module tb_axi_mem_slave;
    logic clk = 0, rst = 1;
    logic [43:0] r_slave0_ar_msg = '0, w_slave0_aw_msg = '0;
    logic r_slave0_ar_val = 0, r_slave0_ar_rdy, r_slave0_r_val, r_slave0_r_rdy = 0;
    logic [70:0] r_slave0_r_msg;
    logic w_slave0_aw_val = 0, w_slave0_aw_rdy, w_slave0_w_val = 0, w_slave0_w_rdy;
    logic [72:0] w_slave0_w_msg = '0;
    logic [5:0] w_slave0_b_msg;
    logic w_slave0_b_val, w_slave0_b_rdy = 0;
    int checks = 0, errors = 0;
    logic [70:0] rb_msg [256];
    int rb_cyc [256];
    typedef struct {
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [1:0]  bresp;
        logic [63:0] rdata;
        logic [1:0]  rresp;
    } vec_t;
    vec_t vecs [7];

    axi_mem_slave #(.MEM_WORDS(256)) dut (
        .clk(clk), .rst(rst),
        .r_slave0_ar_msg(r_slave0_ar_msg), .r_slave0_ar_val(r_slave0_ar_val), .r_slave0_ar_rdy(r_slave0_ar_rdy),
        .r_slave0_r_msg(r_slave0_r_msg), .r_slave0_r_val(r_slave0_r_val), .r_slave0_r_rdy(r_slave0_r_rdy),
        .w_slave0_aw_msg(w_slave0_aw_msg), .w_slave0_aw_val(w_slave0_aw_val), .w_slave0_aw_rdy(w_slave0_aw_rdy),
        .w_slave0_w_msg(w_slave0_w_msg), .w_slave0_w_val(w_slave0_w_val), .w_slave0_w_rdy(w_slave0_w_rdy),
        .w_slave0_b_msg(w_slave0_b_msg), .w_slave0_b_val(w_slave0_b_val), .w_slave0_b_rdy(w_slave0_b_rdy)
    );

    always #5 clk = ~clk;

    function automatic logic [3:0]  m_id(input logic [70:0] m);   return m[70:67]; endfunction
    function automatic logic [63:0] m_data(input logic [70:0] m); return m[66:3];  endfunction
    function automatic logic [1:0]  m_resp(input logic [70:0] m); return m[2:1];   endfunction

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timeout waiting for handshake", name);
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n = 0;
        w_slave0_aw_msg = {id, addr, len};
        w_slave0_aw_val = 1;
        while (!w_slave0_aw_rdy && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("aw");
        @(posedge clk); #1;
        w_slave0_aw_val = 0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int n = 0;
        w_slave0_w_msg = {data, strb, last};
        w_slave0_w_val = 1;
        while (!w_slave0_w_rdy && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("w");
        @(posedge clk); #1;
        w_slave0_w_val = 0;
    endtask

    task automatic b_get(output logic [3:0] id, output logic [1:0] resp);
        int n = 0;
        w_slave0_b_rdy = 1;
        while (!w_slave0_b_val && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("b");
        id = w_slave0_b_msg[5:2];
        resp = w_slave0_b_msg[1:0];
        @(posedge clk); #1;
        w_slave0_b_rdy = 0;
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len, input bit rnd);
        int n = 0, nb = 0, cyc = 0;
        bit stall = 0;
        logic [70:0] held = '0;
        r_slave0_ar_msg = {id, addr, len};
        r_slave0_ar_val = 1;
        while (!r_slave0_ar_rdy && n < 50) begin @(posedge clk); #1; n++; end
        if (n == 50) timeout("ar");
        @(posedge clk); #1;
        r_slave0_ar_val = 0;
        chk("r_first_valid", r_slave0_r_val, 1'b1);
        while (nb <= int'(len) && cyc < 400) begin
            r_slave0_r_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (stall) chk("r_stall_stable", {r_slave0_r_val, r_slave0_r_msg}, {1'b1, held});
            stall = 0;
            if (r_slave0_r_val && r_slave0_r_rdy) begin
                rb_msg[nb] = r_slave0_r_msg;
                rb_cyc[nb] = cyc;
                nb++;
            end else if (r_slave0_r_val) begin
                stall = 1;
                held = r_slave0_r_msg;
            end
            @(posedge clk); #1;
            cyc++;
        end
        r_slave0_r_rdy = 0;
        if (nb <= int'(len)) timeout("r_beats");
        chk("r_no_extra", r_slave0_r_val, 1'b0);
    endtask

    initial begin
        logic [3:0] bid;
        logic [1:0] bresp;
        int extra;
        vecs[0] = '{32'h20,       64'h1122334455667788, 8'hFF, 2'b00, 64'h1122334455667788, 2'b00};
        vecs[1] = '{32'h20,       64'hFFFFFFFFFFFFFFFF, 8'h0F, 2'b00, 64'h11223344FFFFFFFF, 2'b00};
        vecs[2] = '{32'h23,       64'h0,                8'h80, 2'b00, 64'h00223344FFFFFFFF, 2'b00};
        vecs[3] = '{32'h24,       64'hAAAAAAAAAAAAAAAA, 8'h30, 2'b00, 64'h0022AAAAFFFFFFFF, 2'b00};
        vecs[4] = '{32'h7F8,      64'hDEADBEEFCAFEF00D, 8'hFF, 2'b00, 64'hDEADBEEFCAFEF00D, 2'b00};
        vecs[5] = '{32'h800,      64'h55,               8'hFF, 2'b11, 64'h0,                2'b11};
        vecs[6] = '{32'hFFFFFFF8, 64'h1,                8'hFF, 2'b11, 64'h0,                2'b11};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {r_slave0_ar_rdy, w_slave0_aw_rdy, w_slave0_w_rdy, r_slave0_r_val, w_slave0_b_val}, 5'b0);
        chk("rst_r_msg", r_slave0_r_msg, 71'h0);
        chk("rst_b_msg", w_slave0_b_msg, 6'h0);
        rst = 0;
        #1;
        chk("rdy_after_rst", {r_slave0_ar_rdy, w_slave0_aw_rdy}, 2'b11);
        w_slave0_w_msg = {64'hBAD, 8'hFF, 1'b1};
        w_slave0_w_val = 1;
        repeat (2) begin @(posedge clk); #1; end
        chk("w_rdy_idle", {w_slave0_w_rdy, w_slave0_b_val}, 2'b00);
        w_slave0_w_val = 0;

        aw_send(4'd3, 32'h10, 8'd1);
        w_send(64'hA5A5A5A5A5A5A5A5, 8'hFF, 1'b0);
        w_send(64'h1234, 8'h03, 1'b1);
        b_get(bid, bresp);
        chk("b031", {bid, bresp}, {4'd3, 2'b00});

        rd_burst(4'd5, 32'h10, 8'd1, 0);
        chk("r032_beat0", {m_id(rb_msg[0]), m_data(rb_msg[0]), m_resp(rb_msg[0]), rb_msg[0][0]}, {4'd5, 64'hA5A5A5A5A5A5A5A5, 2'b00, 1'b0});
        chk("r032_beat1", {m_id(rb_msg[1]), rb_msg[1][18:3], m_resp(rb_msg[1]), rb_msg[1][0]}, {4'd5, 16'h1234, 2'b00, 1'b1});
        chk("r032_timing", {rb_cyc[0], rb_cyc[1]}, {32'd0, 32'd1});

        for (int i = 0; i < 7; i++) begin
            aw_send(4'(i), vecs[i].addr, 8'd0);
            w_send(vecs[i].wdata, vecs[i].strb, 1'b1);
            b_get(bid, bresp);
            chk($sformatf("vec%0d_b", i), {bid, bresp}, {4'(i), vecs[i].bresp});
            rd_burst(4'(i + 1), vecs[i].addr, 8'd0, 0);
            chk($sformatf("vec%0d_r", i), rb_msg[0], {4'(i + 1), vecs[i].rdata, vecs[i].rresp, 1'b1});
        end

        rd_burst(4'd4, 32'h7F8, 8'd1, 0);
        chk("r033_beat0", rb_msg[0], {4'd4, 64'hDEADBEEFCAFEF00D, 2'b00, 1'b0});
        chk("r033_beat1", rb_msg[1], {4'd4, 64'h0, 2'b11, 1'b1});

        aw_send(4'd7, 32'h40, 8'd2);
        w_send(64'h1, 8'hFF, 1'b0);
        w_send(64'h2, 8'hFF, 1'b1);
        w_send(64'h3, 8'hFF, 1'b0);
        b_get(bid, bresp);
        chk("b034_slverr", {bid, bresp}, {4'd7, 2'b10});
        rd_burst(4'd7, 32'h40, 8'd2, 0);
        chk("r034_data", {m_data(rb_msg[0]), m_data(rb_msg[1]), m_data(rb_msg[2])}, {64'h1, 64'h2, 64'h3});

        aw_send(4'd8, 32'h7F8, 8'd1);
        w_send(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b0);
        w_send(64'h77, 8'hFF, 1'b0);
        b_get(bid, bresp);
        chk("b_decerr_prio", {bid, bresp}, {4'd8, 2'b11});

        aw_send(4'd6, 32'h100, 8'd7);
        for (int k = 0; k < 8; k++) w_send(64'h1000 + 64'(k), 8'hFF, k == 7);
        b_get(bid, bresp);
        chk("b035", {bid, bresp}, {4'd6, 2'b00});
        rd_burst(4'd10, 32'h100, 8'd7, 1);
        for (int k = 0; k < 8; k++)
            chk($sformatf("r035_beat%0d", k), rb_msg[k], {4'd10, 64'h1000 + 64'(k), 2'b00, k == 7});

        r_slave0_ar_msg = {4'd9, 32'h100, 8'd3};
        r_slave0_ar_val = 1;
        #1;
        chk("r036_ar_rdy", r_slave0_ar_rdy, 1'b1);
        @(posedge clk); #1;
        r_slave0_ar_val = 0;
        r_slave0_r_rdy = 1;
        repeat (2) begin @(posedge clk); #1; end
        chk("r036_beat2", {r_slave0_r_val, m_data(r_slave0_r_msg)}, {1'b1, 64'h1002});
        rst = 1;
        #1;
        chk("r036_rst_out", {r_slave0_r_val, r_slave0_r_msg}, 72'h0);
        repeat (2) begin @(posedge clk); #1; end
        rst = 0;
        #1;
        chk("r036_ar_rdy_rise", r_slave0_ar_rdy, 1'b1);
        extra = 0;
        repeat (6) begin
            if (r_slave0_r_val) extra++;
            @(posedge clk); #1;
        end
        chk("r036_no_more_r", extra, 0);
        r_slave0_r_rdy = 0;
        rd_burst(4'd2, 32'h40, 8'd0, 0);
        chk("r036_next_ar", rb_msg[0], {4'd2, 64'h1, 2'b00, 1'b1});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
